bpred_train_scheduler: RTL and testbench
========================================

Name: bpred_train_scheduler

Overview:
- Sequential controller around the branch-prediction/learning datapath.
- Owns the 20-entry global history register (GHR) and the pending-B count.
- Queues weight-training requests from mispredictions and applies them to the 228x72-bit weight table as serialized read-modify-write operations.
- Throttles fetch so that neither history nor the training queue can overflow.

Parameters:
- WT_DEPTH, 228, weight table entries.
- GHR_DEPTH, 20, GHR entries (33 bits each: bit0 = taken, bits32:1 = branch address).
- TQ_DEPTH, 4, training request queue depth (power of 2).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_fetchValid  in  1  fetch group predicted this cycle.
- o_fetchReady  out  1  fetch group may be accepted.
- i_passBNum_3  in  3  B instructions consumed by the group (0..4).
- i_newGHREntry_132  in  132  up to 4 new GHR entries; entry k at [k*33+:33]; entry 0 is youngest.
- i_gotErr  in  1  misprediction reported (single-cycle pulse).
- i_errWeightPos_8  in  8  weight row to train (< WT_DEPTH).
- i_errDir  in  1  correct outcome (1 = taken).
- i_errHist_8  in  8  history bits used by the mispredicted prediction.
- i_bRetire  in  1  one pending B resolved correctly.
- o_globalHistoryRegister_660  out  660  GHR contents.
- o_pendingB_8  out  8  unresolved B count.
- o_weightRdEn  out  1  weight table read strobe.
- o_weightRdAddr_8  out  8  read address.
- i_weightRdData_72  in  72  read data, valid exactly 1 cycle after o_weightRdEn.
- o_weightWrEn  out  1  weight write strobe.
- o_weightWrAddr_8  out  8  write address.
- o_weightWrData_72  out  72  write data (9 signed 8-bit weights; weight 8 = bias).
- o_state_2  out  2  FSM state.

Behaviour:

Reset (i_rst_n low at the clock edge):
- GHR = 0, pendingB = 0.
- Queue empty; state = RUN.
- All strobes 0, addresses/data 0.
- o_fetchReady = 0 during reset, then 1 from the first cycle after reset.
- Reset mid-RMW aborts the operation: no write is issued and queued requests are discarded.

Fetch accept (i_fetchValid & o_fetchReady & !i_gotErr):
- GHR shifts toward older positions by i_passBNum_3 entries.
- New entries 0..passBNum-1 fill positions 0..passBNum-1; the oldest entries fall off.
- pendingB += passBNum.
- i_passBNum_3 > 4 is treated as 4.

o_fetchReady = (state != FLUSH) & (pendingB + 4 <= GHR_DEPTH) & (queue count <= TQ_DEPTH-2).

i_bRetire:
- Decrements pendingB, saturating at 0.
- With a same-cycle accept, the net change is passBNum - 1.

i_gotErr (priority over fetch accept and retire):
- Pushes {errWeightPos, errDir, errHist} into the queue.
- Discards the youngest pendingB GHR entries by shifting back; the vacated old positions fill with 0.
- pendingB = 0; state → FLUSH.
- If the queue is full, the request is dropped. The ready rule makes this unreachable in a legal flow; the bench flags it.

FSM:
- RUN: if queue non-empty → RD.
- RD: o_weightRdEn = 1, o_weightRdAddr_8 = head address → WR.
- WR:
  - o_weightWrEn = 1 to the same address; pop head.
  - Data: weight j (0..7) = rd[j] + (errHist[j] == errDir ? +1 : -1).
  - Bias = rd[8] + (errDir ? +1 : -1).
  - Next state: RD if queue non-empty, else RUN.
- FLUSH: lasts exactly 1 cycle, fetch blocked → RD if queue non-empty, else RUN.
- An error arriving during RD/WR enqueues the request; the current RMW completes, and FLUSH is entered after WR.
- Latency: error at cycle t → read at t+2 (t+1 is FLUSH) → write at t+3.
- Back-to-back queued requests to the same address: the second read follows the first write, so the updated value is visible. The table is write-first.

o_state_2 encoding: RUN = 0, RD = 1, WR = 2, FLUSH = 3.

Optional Feature:
- WEIGHT_SATURATE_EN defined: each 8-bit update saturates at +127 / -128.
- Undefined: each update wraps modulo 256 (two's complement).

Test Plan:
- Reset, then accept groups with passBNum 3, 2, 4 → pendingB = 9; GHR positions 0..8 hold the new entries in age order; o_fetchReady stays 1.
- Accept 4-B groups until pendingB = 17 → o_fetchReady = 0. One i_bRetire → pendingB 16, o_fetchReady = 1.
- pendingB = 6, error with errWeightPos = 10, errDir = 1, errHist = 0x0F, read data all 0x05:
  - 6 youngest entries removed, pendingB = 0, FLUSH for 1 cycle.
  - Write at addr 10: weights 0-3 = 0x06, weights 4-7 = 0x04, bias = 0x06.
- Read data with weight 0 = 0x7F, errHist bit0 = errDir:
  - With WEIGHT_SATURATE_EN → 0x7F.
  - Without → 0x80.
- Three errors on consecutive WR cycles, all addr 5, bias starting at 0, errDir = 1 → three RMWs in order; final bias = 3; queue never exceeds TQ_DEPTH; no drop flag.
- Assert i_rst_n = 0 during RD → no write issued, queue empty, state RUN, all outputs at reset values.

Source files
------------

// File: rtl/bpred_train_scheduler.sv
// Branch-predictor training scheduler: GHR and pending-B bookkeeping, fetch throttling and
// serialized weight-table read-modify-write. Define WEIGHT_SATURATE_EN for saturating updates.
//   state | meaning
//   RUN   | idle, fetch allowed, waits for queued training work
//   RD    | read strobe for the head request's weight row
//   WR    | write updated row back, pop head
//   FLUSH | one-cycle fetch block after a misprediction
module bpred_train_scheduler #(
  parameter int WT_DEPTH  = 228,
  parameter int GHR_DEPTH = 20,
  parameter int TQ_DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_fetchValid,
  output logic                       o_fetchReady,
  input  logic [2:0]                 i_passBNum_3,
  input  logic [131:0]               i_newGHREntry_132,
  input  logic                       i_gotErr,
  input  logic [7:0]                 i_errWeightPos_8,
  input  logic                       i_errDir,
  input  logic [7:0]                 i_errHist_8,
  input  logic                       i_bRetire,
  output logic [GHR_DEPTH*33-1:0]    o_globalHistoryRegister_660,
  output logic [7:0]                 o_pendingB_8,
  output logic                       o_weightRdEn,
  output logic [7:0]                 o_weightRdAddr_8,
  input  logic [71:0]                i_weightRdData_72,
  output logic                       o_weightWrEn,
  output logic [7:0]                 o_weightWrAddr_8,
  output logic [71:0]                o_weightWrData_72,
  output logic [1:0]                 o_state_2
);

  localparam int QW = (TQ_DEPTH > 1) ? $clog2(TQ_DEPTH) : 1;
  localparam int CW = QW + 1;
  localparam int GW = GHR_DEPTH * 33;
  localparam logic [GW-1:0] ONES = '1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_WR    = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [GW-1:0] ghr, ghr_next;
  logic [7:0]    pending_b, pend_sum, pend_next;
  logic [1:0]    state;
  logic          flush_pend;

  logic [16:0]   tq [TQ_DEPTH];
  logic [QW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [2:0]    pass_n;
  logic          accept, push, pop, tq_full, tq_empty, addr_ok;
  logic [7:0]    hd_pos, hd_hist;
  logic          hd_dir;
  logic [71:0]   wr_row;

  function automatic logic [7:0] upd(input logic [7:0] w, input logic up);
`ifdef WEIGHT_SATURATE_EN
    if (up && w == 8'h7F) return w;
    if (!up && w == 8'h80) return w;
`endif
    return up ? w + 8'd1 : w - 8'd1;
  endfunction

  assign pass_n   = (i_passBNum_3 > 3'd4) ? 3'd4 : i_passBNum_3;
  assign tq_full  = (count == CW'(TQ_DEPTH));
  assign tq_empty = (count == '0);
  // Out-of-range rows cannot exist in the table, so such requests are never queued.
  assign addr_ok  = (i_errWeightPos_8 < 8'(WT_DEPTH));

  assign o_fetchReady = i_rst_n && (state != ST_FLUSH) &&
                        (pending_b + 8'd4 <= 8'(GHR_DEPTH)) &&
                        (count <= CW'(TQ_DEPTH - 2));
  assign accept = i_fetchValid && o_fetchReady && !i_gotErr;
  assign pop    = (state == ST_WR);
  assign push   = i_gotErr && addr_ok && (!tq_full || pop);

  assign hd_pos  = tq[head][16:9];
  assign hd_dir  = tq[head][8];
  assign hd_hist = tq[head][7:0];

  always_comb begin
    ghr_next = ghr;
    if (i_gotErr)
      ghr_next = ghr >> (33 * int'(pending_b));
    else if (accept)
      ghr_next = (ghr << (33 * int'(pass_n))) |
                 (GW'(i_newGHREntry_132) & ~(ONES << (33 * int'(pass_n))));
  end

  always_comb begin
    pend_sum  = pending_b + (accept ? 8'(pass_n) : 8'd0);
    pend_next = pend_sum;
    if (i_gotErr)
      pend_next = 8'd0;
    else if (i_bRetire && pend_sum != 8'd0)
      pend_next = pend_sum - 8'd1;
  end

  always_comb begin
    wr_row = '0;
    for (int j = 0; j < 8; j++)
      wr_row[j*8 +: 8] = upd(i_weightRdData_72[j*8 +: 8], hd_hist[j] == hd_dir);
    wr_row[71:64] = upd(i_weightRdData_72[71:64], hd_dir);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ghr        <= '0;
      pending_b  <= '0;
      state      <= ST_RUN;
      flush_pend <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      ghr       <= ghr_next;
      pending_b <= pend_next;
      if (push) tail <= tail + QW'(1);
      if (pop)  head <= head + QW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case (state)
        ST_RUN: begin
          if (i_gotErr)       state <= ST_FLUSH;
          else if (!tq_empty) state <= ST_RD;
        end
        ST_RD: begin
          state <= ST_WR;
          if (i_gotErr) flush_pend <= 1'b1;
        end
        ST_WR: begin
          // A misprediction seen during the RMW is honoured once the write is out.
          if (i_gotErr || flush_pend) begin
            state      <= ST_FLUSH;
            flush_pend <= 1'b0;
          end else if (count > CW'(1)) begin
            state <= ST_RD;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          if (i_gotErr)       state <= ST_FLUSH;
          else if (!tq_empty) state <= ST_RD;
          else                state <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && push)
      tq[tail] <= {i_errWeightPos_8, i_errDir, i_errHist_8};
  end

  assign o_globalHistoryRegister_660 = ghr;
  assign o_pendingB_8      = pending_b;
  assign o_state_2         = state;
  assign o_weightRdEn      = i_rst_n && (state == ST_RD);
  assign o_weightRdAddr_8  = o_weightRdEn ? hd_pos : 8'd0;
  assign o_weightWrEn      = i_rst_n && (state == ST_WR);
  assign o_weightWrAddr_8  = o_weightWrEn ? hd_pos : 8'd0;
  assign o_weightWrData_72 = o_weightWrEn ? wr_row : 72'd0;

endmodule

// File: tb/tb_bpred_train_scheduler.sv
// Directed bench for bpred_train_scheduler; weight writes are checked by a scoreboard monitor.
module tb_bpred_train_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fetch_valid = 1'b0;
  logic         fetch_ready;
  logic [2:0]   pass_b = '0;
  logic [131:0] new_ghr = '0;
  logic         got_err = 1'b0;
  logic [7:0]   err_pos = '0;
  logic         err_dir = 1'b0;
  logic [7:0]   err_hist = '0;
  logic         b_retire = 1'b0;
  logic [659:0] ghr;
  logic [7:0]   pend;
  logic         rd_en;
  logic [7:0]   rd_addr;
  logic [71:0]  rd_data = '0;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [71:0]  wr_data;
  logic [1:0]   state;

  logic [71:0]  mem [256];
  logic [79:0]  exp_q [$];
  int checks = 0;
  int errors = 0;

  bpred_train_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetchValid(fetch_valid), .o_fetchReady(fetch_ready),
    .i_passBNum_3(pass_b), .i_newGHREntry_132(new_ghr),
    .i_gotErr(got_err), .i_errWeightPos_8(err_pos), .i_errDir(err_dir), .i_errHist_8(err_hist),
    .i_bRetire(b_retire),
    .o_globalHistoryRegister_660(ghr), .o_pendingB_8(pend),
    .o_weightRdEn(rd_en), .o_weightRdAddr_8(rd_addr), .i_weightRdData_72(rd_data),
    .o_weightWrEn(wr_en), .o_weightWrAddr_8(wr_addr), .o_weightWrData_72(wr_data),
    .o_state_2(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ent(input int g, input int k);
    return {24'h91A2B3, 4'(g), 4'(k), 1'b1};
  endfunction

  task automatic fetch(input int g, input logic [2:0] pb);
    fetch_valid = 1'b1;
    pass_b      = pb;
    new_ghr     = {ent(g, 3), ent(g, 2), ent(g, 1), ent(g, 0)};
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic err(input logic [7:0] pos, input logic dir, input logic [7:0] hist);
    got_err  = 1'b1;
    err_pos  = pos;
    err_dir  = dir;
    err_hist = hist;
    tick();
    got_err  = 1'b0;
  endtask

  function automatic logic [32:0] gpos(input int k);
    return ghr[k*33 +: 33];
  endfunction

  // Table model: read data appears in the cycle after the read strobe.
  always @(negedge clk) begin
    if (rd_en) rd_data = mem[rd_addr];
    if (wr_en) mem[wr_addr] = wr_data;
  end

  always @(negedge clk) begin
    logic [79:0] e;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 80'(wr_addr), 80'(e[79:72]));
        chk("wr_data", 80'(wr_data), 80'(e[71:0]));
      end
    end
  end

  initial begin
    logic [32:0] age [9];

    repeat (2) tick();
    chk("rst_ready", 80'(fetch_ready), 80'(0));
    chk("rst_ghr", 80'(|ghr), 80'(0));
    chk("rst_pend", 80'(pend), 80'(0));
    chk("rst_state", 80'(state), 80'(0));
    chk("rst_strobes", 80'({rd_en, wr_en}), 80'(0));
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 80'(fetch_ready), 80'(1));

    fetch(1, 3'd3);
    fetch(2, 3'd2);
    fetch(3, 3'd4);
    chk("pend_9", 80'(pend), 80'(9));
    chk("ready_9", 80'(fetch_ready), 80'(1));
    age = '{ent(3,0), ent(3,1), ent(3,2), ent(3,3), ent(2,0), ent(2,1), ent(1,0), ent(1,1), ent(1,2)};
    for (int i = 0; i < 9; i++) chk($sformatf("ghr_pos%0d", i), 80'(gpos(i)), 80'(age[i]));
    chk("ghr_pos9", 80'(gpos(9)), 80'(0));

    fetch(4, 3'd4);
    chk("ready_13", 80'(fetch_ready), 80'(1));
    fetch(5, 3'd4);
    chk("pend_17", 80'(pend), 80'(17));
    chk("ready_17", 80'(fetch_ready), 80'(0));
    b_retire = 1'b1;
    tick();
    b_retire = 1'b0;
    chk("pend_16", 80'(pend), 80'(16));
    chk("ready_16", 80'(fetch_ready), 80'(1));

    // passBNum 7 clamps to 4, with a same-cycle retire.
    b_retire = 1'b1;
    fetch(6, 3'd7);
    b_retire = 1'b0;
    chk("pend_19", 80'(pend), 80'(19));
    chk("ghr_clamp_pos3", 80'(gpos(3)), 80'(ent(6,3)));
    chk("ghr_clamp_pos4", 80'(gpos(4)), 80'(ent(5,0)));
    chk("ghr_pos18", 80'(gpos(18)), 80'(ent(1,0)));

    b_retire = 1'b1;
    repeat (13) tick();
    b_retire = 1'b0;
    chk("pend_6", 80'(pend), 80'(6));

    mem[10] = {9{8'h05}};
    exp_q.push_back({8'd10, 72'h06_04040404_06060606});
    fetch_valid = 1'b1;
    b_retire    = 1'b1;
    err(8'd10, 1'b1, 8'h0F);
    fetch_valid = 1'b0;
    b_retire    = 1'b0;
    chk("err_state_flush", 80'(state), 80'(3));
    chk("err_pend", 80'(pend), 80'(0));
    chk("err_ready", 80'(fetch_ready), 80'(0));
    chk("err_ghr0", 80'(gpos(0)), 80'(ent(5,2)));
    chk("err_ghr2", 80'(gpos(2)), 80'(ent(4,0)));
    chk("err_ghr12", 80'(gpos(12)), 80'(ent(1,0)));
    chk("err_ghr13", 80'(gpos(13)), 80'(ent(1,1)));
    chk("err_ghr_tail", 80'(|ghr[659:14*33]), 80'(0));
    tick();
    chk("rd_state", 80'(state), 80'(1));
    chk("rd_strobe", 80'({rd_en, rd_addr}), 80'({1'b1, 8'd10}));
    chk("rd_ready", 80'(fetch_ready), 80'(1));
    tick();
    chk("wr_state", 80'(state), 80'(2));
    tick();
    chk("run_state", 80'(state), 80'(0));

    mem[20] = {8'h00, 48'h0, 8'h80, 8'h7F};
`ifdef WEIGHT_SATURATE_EN
    exp_q.push_back({8'd20, 8'h01, 48'hFFFFFFFFFFFF, 8'h80, 8'h7F});
`else
    exp_q.push_back({8'd20, 8'h01, 48'hFFFFFFFFFFFF, 8'h7F, 8'h80});
`endif
    err(8'd20, 1'b1, 8'h01);
    repeat (3) tick();
    chk("sat_done_state", 80'(state), 80'(0));

    // Three requests to row 5, each raised in the previous request's WR cycle.
    mem[5] = '0;
    exp_q.push_back({8'd5, 72'h01_FFFFFFFFFFFFFFFF});
    exp_q.push_back({8'd5, 72'h02_0000000000000000});
    exp_q.push_back({8'd5, 72'h03_01FF01FF01FF01FF});
    err(8'd5, 1'b1, 8'h00);
    repeat (2) tick();
    chk("chain_wr1", 80'(state), 80'(2));
    err(8'd5, 1'b1, 8'hFF);
    chk("chain_flush1", 80'(state), 80'(3));
    repeat (2) tick();
    chk("chain_wr2", 80'(state), 80'(2));
    err(8'd5, 1'b1, 8'hAA);
    chk("chain_flush2", 80'(state), 80'(3));
    repeat (3) tick();
    chk("chain_done", 80'(state), 80'(0));
    b_retire = 1'b1;
    tick();
    b_retire = 1'b0;
    chk("retire_sat0", 80'(pend), 80'(0));

    // Error during RD, then reset while the second request is being read.
    mem[7] = {9{8'h10}};
    mem[8] = {9{8'h22}};
    exp_q.push_back({8'd7, 72'h0F_1111111111111111});
    err(8'd7, 1'b0, 8'h00);
    tick();
    chk("rdq_state_rd", 80'(state), 80'(1));
    err(8'd8, 1'b1, 8'h00);
    chk("rdq_state_wr", 80'(state), 80'(2));
    tick();
    chk("rdq_flush_after_wr", 80'(state), 80'(3));
    tick();
    chk("rdq_rd_addr", 80'({state, rd_addr}), 80'({2'd1, 8'd8}));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_strobe", 80'(rd_en), 80'(0));
    tick();
    chk("rst_mid_state", 80'(state), 80'(0));
    chk("rst_mid_outs", 80'({wr_en, rd_en, fetch_ready, rd_addr, wr_addr}), 80'(0));
    chk("rst_mid_wdata", 80'(wr_data), 80'(0));
    chk("rst_mid_pend", 80'(pend), 80'(0));
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_mid_queue_gone", 80'(state), 80'(0));

    chk("sb_drained", 80'(exp_q.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
